ade9078_spi_sequencer: RTL and testbench

Transaction controller that drives the iCE40 SB_SPI hard-IP system bus to run complete ADE9078 register reads and writes. It sits between the metering front-end logic and the SPI hard-IP wrapper. It performs one-time master configuration after reset, then converts single register requests into command-header plus 16- or 32-bit data byte sequences, with chip-select framing and status polling.

---
 rtl/ade9078_spi_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ade9078_spi_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ade9078_spi_sequencer.sv
// ADE9078 register read/write sequencer driving the iCE40 SB_SPI system bus.
// Optional watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module ade9078_spi_sequencer #(
   parameter logic [5:0]  CLK_DIV        = 6'd3,
   parameter int unsigned CS_IDX         = 0,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_wide,
   input  logic [11:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        sb_stb,
   output logic        sb_rw,
   output logic [7:0]  sb_adr,
   output logic [7:0]  sb_dat_o,
   input  logic [7:0]  sb_dat_i,
   input  logic        sb_ack
);

   localparam logic [3:0] S_INIT     = 4'd0;
   localparam logic [3:0] S_IDLE     = 4'd1;
   localparam logic [3:0] S_CS_ON    = 4'd2;
   localparam logic [3:0] S_POLL_T   = 4'd3;
   localparam logic [3:0] S_TX       = 4'd4;
   localparam logic [3:0] S_POLL_R   = 4'd5;
   localparam logic [3:0] S_RX       = 4'd6;
   localparam logic [3:0] S_CS_OFF   = 4'd7;
   localparam logic [3:0] S_POLL_TIP = 4'd8;
   localparam logic [3:0] S_DONE     = 4'd9;

   localparam logic [7:0] A_SPICR0  = 8'h08;
   localparam logic [7:0] A_SPICR1  = 8'h09;
   localparam logic [7:0] A_SPICR2  = 8'h0A;
   localparam logic [7:0] A_SPIBR   = 8'h0B;
   localparam logic [7:0] A_SPISR   = 8'h0C;
   localparam logic [7:0] A_SPITXDR = 8'h0D;
   localparam logic [7:0] A_SPIRXDR = 8'h0E;
   localparam logic [7:0] A_SPICSR  = 8'h0F;

   localparam int unsigned SR_TIP  = 7;
   localparam int unsigned SR_TRDY = 4;
   localparam int unsigned SR_RRDY = 3;

   localparam logic [7:0] CSR_SEL = 8'(1 << CS_IDX);

   if (CS_IDX > 3 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("ade9078_spi_sequencer: CS_IDX must be 0..3 and TIMEOUT_CYCLES >= 2");
   end

   logic [3:0]  state_q, state_d;
   logic [2:0]  init_idx_q, init_idx_d;
   logic        stb_q, stb_d;
   logic        rw_q, rw_d;
   logic [7:0]  adr_q, adr_d;
   logic [7:0]  dat_q, dat_d;
   logic [47:0] tx_q, tx_d;
   logic [2:0]  byte_idx_q, byte_idx_d;
   logic [2:0]  last_idx_q, last_idx_d;
   logic        wr_q, wr_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        busy_q, busy_d;

   logic        acked;
   logic        acc_en;
   logic        acc_rw;
   logic [7:0]  acc_adr;
   logic [7:0]  acc_dat;
   logic [31:0] wdata_slot;

`ifdef SPI_SEQ_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            wd_expired;
`endif

   assign wdata_slot = !req_write ? 32'h0000_0000 :
                       (req_wide ? req_wdata : {req_wdata[15:0], 16'h0000});

   // Next-state: each bus state names one access; the shared strobe logic issues it.
   always_comb begin
      state_d     = state_q;
      init_idx_d  = init_idx_q;
      stb_d       = stb_q;
      rw_d        = rw_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      tx_d        = tx_q;
      byte_idx_d  = byte_idx_q;
      last_idx_d  = last_idx_q;
      wr_d        = wr_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      acc_en      = 1'b0;
      acc_rw      = 1'b0;
      acc_adr     = 8'h00;
      acc_dat     = 8'h00;
      acked       = stb_q & sb_ack;
`ifdef SPI_SEQ_TIMEOUT_EN
      wd_expired  = (wd_q >= WD_W'(TIMEOUT_CYCLES - 1));
      wd_d        = wd_q;
`endif

      case (state_q)
         S_INIT: begin
            acc_en = 1'b1;
            acc_rw = 1'b1;
            case (init_idx_q)
               3'd0:    begin acc_adr = A_SPICR0; acc_dat = 8'h00;             end
               3'd1:    begin acc_adr = A_SPICR1; acc_dat = 8'h80;             end
               3'd2:    begin acc_adr = A_SPIBR;  acc_dat = {2'b00, CLK_DIV};  end
               3'd3:    begin acc_adr = A_SPICR2; acc_dat = 8'h80;             end
               default: begin acc_adr = A_SPICSR; acc_dat = CSR_SEL;           end
            endcase
            if (acked) begin
               if (init_idx_q == 3'd4) state_d = S_IDLE;
               else                    init_idx_d = init_idx_q + 3'd1;
            end
         end
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               wr_d       = req_write;
               last_idx_d = req_wide ? 3'd5 : 3'd3;
               byte_idx_d = 3'd0;
               rdata_d    = 32'h0000_0000;
               err_d      = 1'b0;
               tx_d       = {req_addr, ~req_write, 3'b000, wdata_slot};
               state_d    = S_CS_ON;
            end
         end
         S_CS_ON: begin
            acc_en = 1'b1; acc_rw = 1'b1; acc_adr = A_SPICR2; acc_dat = 8'hC0;
            if (acked) state_d = S_POLL_T;
         end
         S_POLL_T: begin
            acc_en = 1'b1; acc_adr = A_SPISR;
            if (acked && sb_dat_i[SR_TRDY]) state_d = S_TX;
         end
         S_TX: begin
            acc_en = 1'b1; acc_rw = 1'b1; acc_adr = A_SPITXDR; acc_dat = tx_q[47:40];
            if (acked) begin
               tx_d    = {tx_q[39:0], 8'h00};
               state_d = S_POLL_R;
            end
         end
         S_POLL_R: begin
            acc_en = 1'b1; acc_adr = A_SPISR;
            if (acked && sb_dat_i[SR_RRDY]) state_d = S_RX;
         end
         S_RX: begin
            acc_en = 1'b1; acc_adr = A_SPIRXDR;
            if (acked) begin
               // The two header bytes clock out garbage; only data slots of reads land in rdata.
               if (byte_idx_q >= 3'd2 && !wr_q) rdata_d = {rdata_q[23:0], sb_dat_i};
               byte_idx_d = byte_idx_q + 3'd1;
               state_d    = (byte_idx_q == last_idx_q) ? S_CS_OFF : S_POLL_T;
            end
         end
         S_CS_OFF: begin
            acc_en = 1'b1; acc_rw = 1'b1; acc_adr = A_SPICR2; acc_dat = 8'h80;
            if (acked) state_d = S_POLL_TIP;
         end
         S_POLL_TIP: begin
            acc_en = 1'b1; acc_adr = A_SPISR;
            if (acked && !sb_dat_i[SR_TIP]) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_INIT;
         end
      endcase

      if (acked) begin
         stb_d = 1'b0;
      end else if (acc_en && !stb_q) begin
         stb_d = 1'b1;
         rw_d  = acc_rw;
         adr_d = acc_adr;
         dat_d = acc_dat;
      end

`ifdef SPI_SEQ_TIMEOUT_EN
      // A stuck transaction releases CS; a stuck release gives up and reports.
      if (wd_expired && state_d == state_q) begin
         case (state_q)
            S_CS_ON, S_POLL_T, S_TX, S_POLL_R, S_RX: begin
               state_d = S_CS_OFF;
               stb_d   = 1'b0;
               err_d   = 1'b1;
               rdata_d = 32'h0000_0000;
            end
            S_CS_OFF, S_POLL_TIP: begin
               state_d = S_DONE;
               stb_d   = 1'b0;
               err_d   = 1'b1;
               rdata_d = 32'h0000_0000;
            end
            default: ;
         endcase
      end
      if (state_d != state_q)  wd_d = '0;
      else if (!wd_expired)    wd_d = wd_q + WD_W'(1);
`endif

      req_ready_d = (state_d == S_IDLE);
      rsp_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_INIT;
         init_idx_q  <= 3'd0;
         stb_q       <= 1'b0;
         rw_q        <= 1'b0;
         adr_q       <= 8'h00;
         dat_q       <= 8'h00;
         tx_q        <= 48'h0;
         byte_idx_q  <= 3'd0;
         last_idx_q  <= 3'd0;
         wr_q        <= 1'b0;
         rdata_q     <= 32'h0000_0000;
         err_q       <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         init_idx_q  <= init_idx_d;
         stb_q       <= stb_d;
         rw_q        <= rw_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         tx_q        <= tx_d;
         byte_idx_q  <= byte_idx_d;
         last_idx_q  <= last_idx_d;
         wr_q        <= wr_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

`ifdef SPI_SEQ_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end
`endif

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign busy      = busy_q;
   assign sb_stb    = stb_q;
   assign sb_rw     = rw_q;
   assign sb_adr    = adr_q;
   assign sb_dat_o  = dat_q;

endmodule

// File: tb/tb_ade9078_spi_sequencer.sv
// Bench for ade9078_spi_sequencer: behavioural SB_SPI IP model plus a
// transaction-level reference built from the ADE9078 framing rules.
module tb_ade9078_spi_sequencer;

   localparam int unsigned TO_CYC = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic        req_wide = 1'b0;
   logic [11:0] req_addr = 12'h000;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic        sb_stb;
   logic        sb_rw;
   logic [7:0]  sb_adr;
   logic [7:0]  sb_dat_o;
   logic [7:0]  sb_dat_i = 8'h00;
   logic        sb_ack = 1'b0;

   ade9078_spi_sequencer #(
      .CLK_DIV       (6'd3),
      .CS_IDX        (0),
      .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_wide (req_wide),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .busy     (busy),
      .sb_stb   (sb_stb),
      .sb_rw    (sb_rw),
      .sb_adr   (sb_adr),
      .sb_dat_o (sb_dat_o),
      .sb_dat_i (sb_dat_i),
      .sb_ack   (sb_ack)
   );

   always #5 clk = ~clk;

   // IP model state
   logic [15:0] wlog[$];
   logic [7:0]  rxq[$];
   int          trdy_stall = 0;
   int          wait_cnt = 0;
   bit          rrdy_prev0 = 1'b0;
   bit          tip_prev1 = 1'b0;

   int n_checks = 0;
   int n_fail = 0;
   int n_rsp = 0;
   int n_hs = 0;
   int n_overlap = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] ip_read(input logic [7:0] a);
      logic [7:0] v;
      logic       trdy, rrdy, tip;
      v = 8'h00;
      if (a == 8'h0C) begin
         trdy = (trdy_stall == 0);
         if (trdy_stall > 0) trdy_stall--;
         rrdy = rrdy_prev0 ? 1'b1 : ($urandom_range(0, 3) != 0);
         rrdy_prev0 = !rrdy;
         tip = tip_prev1 ? 1'b0 : ($urandom_range(0, 3) == 0);
         tip_prev1 = tip;
         v = {tip, 2'b00, trdy, rrdy, 3'b000};
      end else if (a == 8'h0E) begin
         if (rxq.size() > 0) v = rxq.pop_front();
         else                v = 8'($urandom);
      end
      return v;
   endfunction

   // Acknowledges each strobe after 0..2 wait cycles.
   always @(posedge clk) begin
      if (rst) begin
         sb_ack <= 1'b0;
         wait_cnt = 0;
      end else begin
         sb_ack <= 1'b0;
         if (sb_stb && !sb_ack) begin
            if (wait_cnt > 0) begin
               wait_cnt--;
            end else begin
               sb_ack <= 1'b1;
               wait_cnt = $urandom_range(0, 2);
               if (sb_rw) wlog.push_back({sb_adr, sb_dat_o});
               else       sb_dat_i <= ip_read(sb_adr);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rsp_valid) n_rsp++;
      if (req_valid && req_ready) n_hs++;
      if (req_ready && (rsp_valid || busy)) n_overlap++;
   end

   function automatic int n_txd();
      int c = 0;
      foreach (wlog[k]) if (wlog[k][15:8] == 8'h0D) c++;
      return c;
   endfunction

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 5000 && !req_ready; i++) @(negedge clk);
      check(tag, 32'(req_ready), 32'd1);
   endtask

   task automatic wait_rsp(input string tag);
      for (int i = 0; i < 20000 && !rsp_valid; i++) @(negedge clk);
      check(tag, 32'(rsp_valid), 32'd1);
   endtask

   task automatic check_reset_vals();
      check("rst_ctl", 32'({req_ready, rsp_valid, rsp_err, busy, sb_stb, sb_rw}), 32'b000100);
      check("rst_bus", 32'({sb_adr, sb_dat_o}), 32'h0);
      check("rst_rdata", rsp_rdata, 32'h0);
   endtask

   task automatic check_init();
      logic [15:0] exp_init[5];
      exp_init = '{16'h0800, 16'h0980, 16'h0B03, 16'h0A80, 16'h0F01};
      wait_ready("init_ready");
      check("init_len", 32'(wlog.size()), 32'd5);
      for (int k = 0; k < 5 && k < wlog.size(); k++) check("init_wr", 32'(wlog[k]), 32'(exp_init[k]));
   endtask

   task automatic send_req(input bit w, input bit wd, input logic [11:0] a, input logic [31:0] d);
      req_write = w; req_wide = wd; req_addr = a; req_wdata = d; req_valid = 1'b1;
      wait_ready("hs_ready");
      @(negedge clk);
      req_valid = 1'b0;
      check("hs_after", 32'({req_ready, busy}), 32'b01);
   endtask

   // Expected bus writes: CS hold, header + data TXDR bytes, CS release.
   task automatic build_exp(input bit w, input bit wd, input logic [11:0] a, input logic [31:0] d,
                            inout logic [15:0] exp_w[$]);
      int          nd;
      logic [15:0] hdr;
      nd  = wd ? 4 : 2;
      hdr = 16'(a) * 16'd16 + (w ? 16'd0 : 16'd8);
      exp_w.push_back(16'h0AC0);
      exp_w.push_back({8'h0D, hdr[15:8]});
      exp_w.push_back({8'h0D, hdr[7:0]});
      for (int k = nd - 1; k >= 0; k--) exp_w.push_back({8'h0D, w ? 8'(d >> (8 * k)) : 8'h00});
      exp_w.push_back(16'h0A80);
   endtask

   task automatic push_rx(input bit wd, input logic [31:0] rxd);
      int nd;
      nd = wd ? 4 : 2;
      rxq.push_back(8'($urandom));
      rxq.push_back(8'($urandom));
      for (int k = nd - 1; k >= 0; k--) rxq.push_back(8'(rxd >> (8 * k)));
   endtask

   task automatic cmp_log(input string tag, input logic [15:0] exp_w[$]);
      check({tag, "_len"}, 32'(wlog.size()), 32'(exp_w.size()));
      for (int k = 0; k < exp_w.size() && k < wlog.size(); k++) check(tag, 32'(wlog[k]), 32'(exp_w[k]));
   endtask

   task automatic run_txn(input bit w, input bit wd, input logic [11:0] a, input logic [31:0] d,
                          input logic [31:0] rxd);
      logic [15:0] exp_w[$];
      logic [31:0] exp_rd;
      wlog.delete();
      rxq.delete();
      push_rx(wd, rxd);
      build_exp(w, wd, a, d, exp_w);
      exp_rd = w ? 32'h0 : (wd ? rxd : (rxd & 32'h0000_FFFF));
      send_req(w, wd, a, d);
      wait_rsp("rsp");
      check("rdata", rsp_rdata, exp_rd);
      check("err", 32'(rsp_err), 32'd0);
      cmp_log("txlog", exp_w);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      int          rsp0, hs0, ov0;
      logic [15:0] exp_w[$];

      // Reset values and INIT sequence
      repeat (3) @(negedge clk);
      check_reset_vals();
      wlog.delete();
      rxq.delete();
      rst = 1'b0;
      check_init();

      // Directed frames
      run_txn(1'b0, 1'b0, 12'h4FE, 32'h0, 32'h0000_1234);
      run_txn(1'b1, 1'b1, 12'h0B7, 32'hDEAD_BEEF, $urandom);

      // Random requests
      for (int n = 0; n < 10; n++)
         run_txn(1'($urandom), 1'($urandom), 12'($urandom), $urandom, $urandom);

      // Stalled TRDY
`ifdef SPI_SEQ_TIMEOUT_EN
      wlog.delete();
      rxq.delete();
      trdy_stall = 1000;
      send_req(1'b0, 1'b1, 12'($urandom), 32'h0);
      wait_rsp("to_rsp");
      check("to_err", 32'(rsp_err), 32'd1);
      check("to_rdata", rsp_rdata, 32'h0);
      exp_w.delete();
      exp_w.push_back(16'h0AC0);
      exp_w.push_back(16'h0A80);
      cmp_log("to_log", exp_w);
      trdy_stall = 0;
      @(negedge clk);
`else
      trdy_stall = 50;
      run_txn(1'b0, 1'b1, 12'($urandom), 32'h0, $urandom);
      check("trdy_polls", 32'(trdy_stall), 32'd0);
`endif

      // Reset during the third TX byte
      wlog.delete();
      rxq.delete();
      push_rx(1'b1, $urandom);
      send_req(1'b1, 1'b1, 12'h123, 32'hCAFE_F00D);
      for (int i = 0; i < 5000 && !(sb_stb && sb_adr == 8'h0D && n_txd() == 2); i++) @(negedge clk);
      check("tx3_seen", 32'(sb_stb && sb_adr == 8'h0D && n_txd() == 2), 32'd1);
      rsp0 = n_rsp;
      rst = 1'b1;
      #1;
      check_reset_vals();
      repeat (4) @(negedge clk);
      check("rst_no_rsp", 32'(n_rsp), 32'(rsp0));
      wlog.delete();
      rxq.delete();
      rst = 1'b0;
      check_init();
      run_txn(1'($urandom), 1'($urandom), 12'($urandom), $urandom, $urandom);

      // req_valid held across two requests
      wlog.delete();
      rxq.delete();
      exp_w.delete();
      hs0 = n_hs; rsp0 = n_rsp; ov0 = n_overlap;
      push_rx(1'b0, $urandom);
      push_rx(1'b0, $urandom);
      build_exp(1'b1, 1'b0, 12'h3A5, 32'h0000_5AA5, exp_w);
      build_exp(1'b1, 1'b0, 12'h7C1, 32'h1234_C3E1, exp_w);
      req_write = 1'b1; req_wide = 1'b0; req_addr = 12'h3A5; req_wdata = 32'h0000_5AA5;
      req_valid = 1'b1;
      wait_ready("b2b_hs1");
      @(negedge clk);
      req_addr = 12'h7C1; req_wdata = 32'h1234_C3E1;
      wait_rsp("b2b_rsp1");
      check("b2b_rdata1", rsp_rdata, 32'h0);
      @(negedge clk);
      wait_ready("b2b_hs2");
      @(negedge clk);
      req_valid = 1'b0;
      wait_rsp("b2b_rsp2");
      check("b2b_hs", 32'(n_hs - hs0), 32'd2);
      check("b2b_rsp", 32'(n_rsp - rsp0), 32'd2);
      check("b2b_overlap", 32'(n_overlap - ov0), 32'd0);
      cmp_log("b2b_log", exp_w);
      @(negedge clk);

      check("overlap_total", 32'(n_overlap), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
